// File: rtl/biu_arb_pkg.sv
// Shared definitions for the bus interface unit arbiter: source IDs, bus
// commands and arbitration mode constants.
package biu_arb_pkg;

  typedef enum logic {
    SRC_IFETCH = 1'b0,
    SRC_LDST   = 1'b1
  } src_e;

  typedef enum logic {
    BUS_CMD_READ  = 1'b0,
    BUS_CMD_WRITE = 1'b1
  } bus_cmd_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int SRC_W = $bits(src_e);

endpackage

// File: rtl/biu_ord_fifo.sv
// Order FIFO remembering which source issued each outstanding bus request,
// so in-order bus responses can be steered back to the right requester.
module biu_ord_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/biu_arb.sv
// Arbitrates instruction-fetch and load/store requests onto one in-order bus
// and routes the responses back by source, with no added latency.
module biu_arb
  import biu_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int OST_DEPTH = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ifetch_req_vld,
  output logic                           ifetch_req_rdy,
  input  logic [ADDR_W-1:0]              ifetch_req_pc,
  output logic                           ifetch_rsp_vld,
  output logic [DATA_W-1:0]              ifetch_rsp_ir,
  input  logic                           ifetch_rsp_rdy,
  input  logic                           ldst_req_vld,
  output logic                           ldst_req_rdy,
  input  logic                           ldst_req_wr,
  input  logic [ADDR_W-1:0]              ldst_req_addr,
  input  logic [DATA_W-1:0]              ldst_req_wdata,
  input  logic [DATA_W/8-1:0]            ldst_req_strb,
  output logic                           ldst_rsp_vld,
  output logic [DATA_W-1:0]              ldst_rsp_rdata,
  input  logic                           ldst_rsp_rdy,
  output logic                           bti_req_vld,
  input  logic                           bti_req_rdy,
  output bus_cmd_e                       bti_req_pkt_cmd,
  output logic [ADDR_W-1:0]              bti_req_pkt_addr,
  output logic [DATA_W-1:0]              bti_req_pkt_data,
  output logic [DATA_W/8-1:0]            bti_req_pkt_strb,
  input  logic                           bti_rsp_vld,
  input  logic [DATA_W-1:0]              bti_rsp_pkt_data,
  output logic                           bti_rsp_rdy,
  output logic [$clog2(OST_DEPTH+1)-1:0] ost_cnt
);

  src_e             sel_src;
  logic             sel_vld;
  logic             lock_q;
  src_e             lock_src_q;
  logic             rr_pref_ldst_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SRC_W-1:0] head_data;
  src_e             head_src;
  logic             req_acc;
  logic             rsp_acc;
  logic             rsp_active;

  // A stalled request keeps its grant so the bus sees a stable packet.
  always_comb begin
    sel_src = SRC_IFETCH;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (ifetch_req_vld && ldst_req_vld) begin
      if (ARB_MODE == ARB_FIXED) sel_src = SRC_LDST;
      else                       sel_src = rr_pref_ldst_q ? SRC_LDST : SRC_IFETCH;
    end else if (ldst_req_vld) begin
      sel_src = SRC_LDST;
    end
  end

  assign sel_vld     = (sel_src == SRC_LDST) ? ldst_req_vld : ifetch_req_vld;
  assign bti_req_vld = rst_n && sel_vld && !fifo_full;
  assign req_acc     = bti_req_vld && bti_req_rdy;

  assign ifetch_req_rdy = rst_n && (sel_src == SRC_IFETCH) && bti_req_rdy && !fifo_full;
  assign ldst_req_rdy   = rst_n && (sel_src == SRC_LDST) && bti_req_rdy && !fifo_full;

  always_comb begin
    bti_req_pkt_cmd  = BUS_CMD_READ;
    bti_req_pkt_addr = ifetch_req_pc;
    bti_req_pkt_data = '0;
    bti_req_pkt_strb = '1;
    if (sel_src == SRC_LDST) begin
      bti_req_pkt_cmd  = ldst_req_wr ? BUS_CMD_WRITE : BUS_CMD_READ;
      bti_req_pkt_addr = ldst_req_addr;
      bti_req_pkt_data = ldst_req_wdata;
      bti_req_pkt_strb = ldst_req_strb;
    end
  end

  // The round-robin preference only moves when the bus actually takes a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q         <= 1'b0;
      lock_src_q     <= SRC_IFETCH;
      rr_pref_ldst_q <= 1'b1;
    end else begin
      lock_q <= bti_req_vld && !bti_req_rdy;
      if (bti_req_vld && !bti_req_rdy) lock_src_q <= sel_src;
      if (req_acc) rr_pref_ldst_q <= (sel_src == SRC_IFETCH);
    end
  end

  assign head_src   = src_e'(head_data);
  assign rsp_active = rst_n && !fifo_empty;

  // Responses with nothing outstanding are left on the bus, never acknowledged.
  assign ifetch_rsp_vld = rsp_active && (head_src == SRC_IFETCH) && bti_rsp_vld;
  assign ldst_rsp_vld   = rsp_active && (head_src == SRC_LDST) && bti_rsp_vld;
  assign bti_rsp_rdy    = rsp_active &&
                          ((head_src == SRC_IFETCH) ? ifetch_rsp_rdy : ldst_rsp_rdy);
  assign rsp_acc        = bti_rsp_vld && bti_rsp_rdy;
  assign ifetch_rsp_ir  = bti_rsp_pkt_data;
  assign ldst_rsp_rdata = bti_rsp_pkt_data;

  biu_ord_fifo #(
    .WIDTH (SRC_W),
    .DEPTH (OST_DEPTH)
  ) u_ord_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_acc),
    .push_data (sel_src),
    .pop       (rsp_acc),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (ost_cnt)
  );

endmodule
